seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed 7-segment digits, range 2..8.
REQ-002 Parameter DIV, default 50000: clocks each digit is driven per scan slot, minimum 2.
REQ-003 Parameter GAP, default 4: all-digits-off clocks between slots (anti-ghosting), minimum 1.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  1 = scanning; 0 = display dark.
REQ-007 load  input  1  one-cycle request to display value_in.
REQ-008 value_in  input  4*NDIG  hex nibbles; nibble k (bits 4k+3:4k) belongs to digit k; digit 0 is least significant.
REQ-009 hex_out  output  4  nibble for the current digit, fed to the hex-to-7-segment decoder.
REQ-010 dig_sel  output  NDIG  one-hot active-high digit strobe; all zero when no digit is driven.
REQ-011 load_ack  output  1  one-cycle pulse when a loaded value becomes the displayed value.

Function
REQ-012 State machine has three states: IDLE (dark), SHOW (digit driven), GAP (blanking).
REQ-013 IDLE: dig_sel=0, hex_out=0, slot counter=0, digit index=0; enable=1 moves to SHOW at digit 0 on the next edge.
REQ-014 SHOW: dig_sel bit [index]=1, hex_out=display nibble [index]; after exactly DIV cycles moves to GAP.
REQ-015 GAP: dig_sel=0, hex_out=0; after exactly GAP cycles moves to SHOW with index+1, wrapping NDIG-1 -> 0.
REQ-016 One full frame lasts exactly NDIG*(DIV+GAP) cycles; the slot counter is sized ceil(log2(max(DIV,GAP))) bits and never overflows.
REQ-017 enable=0 in any state moves to IDLE on the next edge and aborts the slot.
REQ-018 load=1 writes value_in into a shadow register and sets pending; a later load before application overwrites the shadow (latest wins).
REQ-019 Frame boundary = the GAP->SHOW transition from index NDIG-1 to 0; if pending, shadow is copied to the display register, pending clears, load_ack=1 for that cycle.
REQ-020 In IDLE, a pending value is applied on the next edge with load_ack, without waiting for a frame boundary.
REQ-021 A load coinciding with a boundary (or with the IDLE application cycle) is applied in that same cycle from value_in directly; load_ack pulses once.
REQ-022 The display register never changes mid-frame; no torn frame is ever shown.
REQ-023 At most one dig_sel bit is 1 in any cycle.
REQ-024 Outputs are registered; dig_sel and hex_out change together on the same edge.

Reset
REQ-025 rst=1 forces IDLE, index 0, slot counter 0, display register 0, shadow 0, pending 0, dig_sel=0, hex_out=0, load_ack=0 on the next edge.
REQ-026 rst has priority over enable and load, including a load in the same cycle and mid-slot scanning.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN.
REQ-028 Defined: in SHOW, for index>0, if that nibble and all higher nibbles of the display register are 0, dig_sel stays 0 and hex_out=0 for the slot; slot timing is unchanged.
REQ-029 Not defined: every digit is driven in its slot regardless of value; no blanking logic is present.

Verification (NDIG=4, DIV=8, GAP=2; frame=40 cycles)
REQ-030 rst 3 cycles, enable=1 -> dig_sel 0001 for 8 cycles, 0000 for 2, 0010 for 8, ... 1000, then back to 0001 on cycle 41.
REQ-031 load value_in=16'h1234 at cycle 5 of the frame -> hex_out stays on old value until the boundary, then digit0=4, digit1=3, digit2=2, digit3=1; exactly one load_ack.
REQ-032 loads 16'hAAAA then 16'h5555 within one frame -> only 16'h5555 displayed, one load_ack.
REQ-033 enable dropped mid-SHOW of digit 2 -> dig_sel=0 next cycle; load 16'h00F0 while dark -> load_ack next cycle; enable=1 -> digit 0 first.
REQ-034 rst asserted mid-GAP with load=1 -> all outputs 0, display 0, no load_ack.
REQ-035 With LEADING_ZERO_BLANK_EN, display 16'h0070 -> digits 0 and 1 strobed, digits 2 and 3 dark, frame still 40 cycles; display 16'h0000 -> only digit 0 strobed, showing 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous value update.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg_scan_ctrl #(
    parameter int NDIG = 4,
    parameter int DIV  = 50000,
    parameter int GAP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load,
    input  logic [4*NDIG-1:0] value_in,
    output logic [3:0]        hex_out,
    output logic [NDIG-1:0]   dig_sel,
    output logic              load_ack
);

    localparam int MAXC = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NDIG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] disp_q, disp_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic              pend_q, pend_d;
    logic [NDIG-1:0]   dig_sel_q, dig_sel_d;
    logic [3:0]        hex_q, hex_d;
    logic              ack_q, ack_d;
    logic              apply;
    logic              blank;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        disp_d   = disp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        apply    = 1'b0;

        if (load) begin
            shadow_d = value_in;
            pend_d   = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                apply = pend_q | load;
                if (enable) state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SHOW;
                    if (idx_q == IW'(NDIG - 1)) begin
                        idx_d = '0;
                        apply = pend_q | load;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A same-cycle load wins over the older shadow contents.
        if (apply) begin
            disp_d = load ? value_in : shadow_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    always_comb begin
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d != '0 && (disp_d >> {idx_d, 2'b00}) == '0) blank = 1'b1;
`endif
        dig_sel_d = '0;
        hex_d     = '0;
        if (state_d == S_SHOW && !blank) begin
            dig_sel_d = NDIG'(1) << idx_d;
            hex_d     = disp_d[{idx_d, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            dig_sel_q <= '0;
            hex_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            dig_sel_q <= dig_sel_d;
            hex_q     <= hex_d;
            ack_q     <= ack_d;
        end
    end

    assign dig_sel  = dig_sel_q;
    assign hex_out  = hex_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model, directed then random stimulus.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int SLOT  = DIV + GAP;
    localparam int FRAME = NDIG * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  hex_out;
    logic [3:0]  dig_sel;
    logic        load_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;

    bit          m_run;
    int          m_pos;
    logic [15:0] m_disp, m_shadow;
    bit          m_pend, m_ack;

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .value_in(value_in), .hex_out(hex_out),
        .dig_sel(dig_sel), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: scanning is a position within a 40-cycle frame.
    task automatic model(input bit r, input bit e, input bit l,
                         input logic [15:0] v);
        bit at_apply;
        if (r) begin
            m_run = 0; m_pos = 0; m_disp = 0; m_shadow = 0;
            m_pend = 0; m_ack = 0;
            return;
        end
        at_apply = !m_run || (m_pos == FRAME - 1);
        m_ack = 0;
        if (at_apply && (m_pend || l)) begin
            m_disp = l ? v : m_shadow;
            m_ack  = 1;
        end
        if (l) m_shadow = v;
        m_pend = (m_pend || l) && !m_ack;
        if (!e) begin
            m_run = 0; m_pos = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    task automatic compare();
        int          d;
        logic [3:0]  esel, ehex;
        logic [15:0] hi;
        esel = 0; ehex = 0;
        if (m_run && (m_pos % SLOT) < DIV) begin
            d    = m_pos / SLOT;
            hi   = m_disp >> (4 * d);
            esel = 4'(1 << d);
            ehex = 4'(hi);
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && hi == 0) begin
                esel = 0; ehex = 0;
            end
`endif
        end
        check("dig_sel", 32'(dig_sel), 32'(esel));
        check("hex_out", 32'(hex_out), 32'(ehex));
        check("load_ack", 32'(load_ack), 32'(m_ack));
        check("onehot", 32'($countones(dig_sel) <= 1), 32'd1);
    endtask

    task automatic step(input bit r, input bit e, input bit l,
                        input logic [15:0] v);
        rst = r; enable = e; load = l; value_in = v;
        @(posedge clk);
        model(r, e, l, v);
        #1;
        compare();
        if (load_ack) ack_cnt++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        repeat (3) step(1, 0, 0, 16'h0);
        check("rst_sel", 32'(dig_sel), 32'd0);

        for (int i = 0; i < 44; i++) step(0, 1, 0, 16'h0);

        ack_cnt = 0;
        for (int i = 0; i < 45; i++) step(0, 1, i == 5, 16'h1234);
        check("ack_once_1234", ack_cnt, 32'd1);

        ack_cnt = 0;
        for (int i = 0; i < 45; i++)
            step(0, 1, i == 3 || i == 9, (i == 3) ? 16'hAAAA : 16'h5555);
        check("ack_once_5555", ack_cnt, 32'd1);

        for (int i = 0; i < 24; i++) step(0, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 1, 16'h00F0);
        step(0, 0, 0, 16'h0);
        for (int i = 0; i < 45; i++) step(0, 1, 0, 16'h0);

        for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0);
        step(1, 1, 1, 16'hBEEF);
        check("rst_gap_ack", 32'(load_ack), 32'd0);
        for (int i = 0; i < 45; i++) step(0, 1, 0, 16'h0);

        step(0, 0, 1, 16'h0070);
        for (int i = 0; i < 42; i++) step(0, 1, 0, 16'h0);
        step(0, 0, 1, 16'h0000);
        for (int i = 0; i < 42; i++) step(0, 1, 0, 16'h0);

        for (int i = 0; i < 4000; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if ($urandom_range(3) == 0) v = v & 16'h00FF;
            step($urandom_range(299) == 0, $urandom_range(79) != 0,
                 $urandom_range(24) == 0, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
